// File: rtl/dmem_lat.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lat
//  Purpose  : Programmable-latency data memory for the cardinal processor's
//             data port. A request is accepted with memEn, the access happens
//             LATENCY edges later, and memReady pulses for one cycle on
//             completion. Writes are lane-masked to support b/h/w/d stores.
//             All vectors use big-endian bit numbering: bit 0 is the MSB.
//  Ports    : Clock    - system clock, all state changes on posedge
//             Reset    - synchronous, active-high
//             memEn    - request valid
//             memWrEn  - 1 = write, 0 = read (sampled with memEn)
//             memAddr  - word address
//             dataIn   - write data
//             laneMask - write lane enables, bit i covers data lane i
//             dataOut  - registered read data
//             memReady - one-cycle completion pulse
//             busy     - a request is outstanding
//             addrErr  - sticky out-of-range flag, cleared only by Reset
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lat #(
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  memEn,
    input  logic                                  memWrEn,
    input  logic [0:ADDR_WIDTH-1]                 memAddr,
    input  logic [0:DATA_WIDTH-1]                 dataIn,
    input  logic [0:DATA_WIDTH/LANE_WIDTH-1]      laneMask,
    output logic [0:DATA_WIDTH-1]                 dataOut,
    output logic                                  memReady,
    output logic                                  busy,
    output logic                                  addrErr
);

    localparam int c_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int c_CNT_W = $clog2(LATENCY) + 1;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Storage array; its name is kept stable for hierarchical preload/dump.
    logic [0:DATA_WIDTH-1] MEM [0:DEPTH-1];

    state_t                 r_state;
    state_t                 w_next;
    logic [c_CNT_W-1:0]     r_cnt;

    // Request fields captured at acceptance; later input changes are ignored.
    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [0:DATA_WIDTH-1]  r_data;
    logic [0:c_LANES-1]     r_mask;

    logic [0:DATA_WIDTH-1]  r_dout;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_access;
    logic                   w_in_range;
    logic [c_IDX_W-1:0]     w_idx;
    logic [0:DATA_WIDTH-1]  w_rd;
    logic [0:DATA_WIDTH-1]  w_merged;

    // Zero-extend by one bit so DEPTH == 2**ADDR_WIDTH is representable.
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
    assign w_idx      = r_addr[c_IDX_W-1:0];
    assign w_rd       = MEM[w_idx];

    // ------------------------------------------------------------------
    // Next-state and handshake outputs.
    // DONE also accepts a new request: the completing cycle doubles as the
    // idle slot, which gives a request spacing of LATENCY+1 cycles and
    // re-accepts a memEn still held on the edge after memReady.
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        memReady = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (memEn) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_access = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                memReady = 1'b1;
                if (memEn) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (w_accept) begin
            r_wr   <= memWrEn;
            r_addr <= memAddr;
            r_data <= dataIn;
            r_mask <= laneMask;
        end
    end

    // ------------------------------------------------------------------
    // Lane merge: unmasked lanes keep the current word contents, so a
    // whole-word write realises the byte-enable behaviour.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        assign w_merged[i*LANE_WIDTH +: LANE_WIDTH] =
            r_mask[i] ? r_data[i*LANE_WIDTH +: LANE_WIDTH]
                      : w_rd[i*LANE_WIDTH +: LANE_WIDTH];
    end

    // Memory is never reset; Reset only blocks a coincident access.
    always_ff @(posedge Clock) begin
        if (!Reset && w_access && r_wr && w_in_range) begin
            MEM[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_dout <= '0;
            r_err  <= 1'b0;
        end else if (w_access) begin
            if (!w_in_range) begin
                r_err <= 1'b1;
            end
            if (!r_wr) begin
                r_dout <= w_in_range ? w_rd : '0;
            end
        end
    end

    assign dataOut = r_dout;
    assign addrErr = r_err;

endmodule
`default_nettype wire
